// File: rtl/prog_loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the serial program loader.
//   loader_state_t : top-level load sequencer states
//   rx_state_t     : UART receiver states
//   RAM_DEPTH      : number of words in the program/data RAM
//   ADDR_W         : RAM address width
// ---------------------------------------------------------------------------
package loader_pkg;

    localparam int RAM_DEPTH = 256;
    localparam int ADDR_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        DONE,
        ERR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// ---------------------------------------------------------------------------
// prog_loader_if
// RAM-side bus of the program loader.
//   ram_write : one-cycle RAM write strobe
//   ram_addr  : RAM address
//   ram_data  : RAM write data
//   cpu_hold  : loader owns the RAM bus; processor held in reset
// The system-level mux selects these RAM inputs while cpu_hold is high and
// the processor's own bus otherwise.
// Modports: master (loader drives), slave (bus mux / RAM side observes).
// ---------------------------------------------------------------------------
interface prog_loader_if;
    import loader_pkg::*;

    logic              ram_write;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_data;
    logic              cpu_hold;

    modport master (output ram_write, output ram_addr, output ram_data, output cpu_hold);
    modport slave  (input  ram_write, input  ram_addr, input  ram_data, input  cpu_hold);

endinterface

// File: rtl/prog_loader_uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver.
//   clk        : system clock
//   reset_n    : asynchronous reset, active low
//   rx         : serial input, idles high, asynchronous to clk
//   byte_valid : one-cycle pulse, one cycle after a good stop-bit sample
//   byte_data  : received byte, valid with byte_valid
//   frame_err  : one-cycle pulse when the stop bit is sampled low
// ---------------------------------------------------------------------------
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_t        state;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    // Edge detection uses the previous synchronised sample so a line held
    // low (break or bad stop bit) does not retrigger a frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    // A start bit that has gone high by mid-bit is a glitch.
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_BITS;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_BITS: begin
                    if (cnt == FULL_LAST) begin
                        cnt   <= '0;
                        shift <= {rx_sync, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// Serial program loader: receives a length byte N (0 means 256) followed by
// N data bytes over UART and writes them to RAM from address 0, holding the
// processor in reset while loading.
//   clk      : system clock
//   reset_n  : asynchronous reset, active low
//   rx       : UART serial input
//   start    : one-cycle pulse arming a load (IDLE/DONE/ERR only)
//   bus      : RAM write bus and cpu_hold (prog_loader_if.master)
//   done     : load finished, held until the next start
//   err      : framing error latched, cleared by the next start
// ---------------------------------------------------------------------------
module prog_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                rx,
    input  logic                start,
    prog_loader_if.master       bus,
    output logic                done,
    output logic                err
);

    localparam int REM_W = ADDR_W + 1;

    loader_state_t    state;
    logic [REM_W-1:0] remaining;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             frame_err;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    // ram_addr doubles as the write address counter. It advances on the edge
    // that ends the write cycle, which is also where the last write hands
    // over to DONE, so ram_write can never be high two cycles in a row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            remaining     <= '0;
            bus.ram_write <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_data  <= '0;
            bus.cpu_hold  <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= LEN;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        bus.ram_addr <= '0;
                        bus.cpu_hold <= 1'b1;
                    end
                end
                LEN: begin
                    if (frame_err) begin
                        state        <= ERR;
                        bus.cpu_hold <= 1'b0;
                        err          <= 1'b1;
                    end else if (byte_valid) begin
                        remaining <= (byte_data == 8'd0) ? REM_W'(RAM_DEPTH)
                                                         : {1'b0, byte_data};
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (bus.ram_write) begin
                        bus.ram_write <= 1'b0;
                        bus.ram_addr  <= bus.ram_addr + 8'd1;
                        if (remaining == '0) begin
                            state        <= DONE;
                            bus.cpu_hold <= 1'b0;
                            done         <= 1'b1;
                        end
                    end else if (frame_err) begin
                        state        <= ERR;
                        bus.cpu_hold <= 1'b0;
                        err          <= 1'b1;
                    end else if (byte_valid) begin
                        bus.ram_write <= 1'b1;
                        bus.ram_data  <= byte_data;
                        remaining     <= remaining - REM_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
// Self-checking bench for prog_loader with CLKS_PER_BIT = 8. Expected RAM
// writes are queued as bytes are sent and matched against every ram_write
// the DUT produces.
// ---------------------------------------------------------------------------
module tb_prog_loader;

    localparam int CPB = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rx = 1'b1;
    logic start = 1'b0;
    logic done;
    logic err;

    prog_loader_if bus ();

    prog_loader #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rx      (rx),
        .start   (start),
        .bus     (bus),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    int writes_seen = 0;
    int last_write_cycle = -1;
    int done_rise_cycle = -1;
    logic prev_write = 1'b0;
    logic done_prev = 1'b0;
    logic [15:0] exp_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Sends one 8N1 frame; stop_bit = 0 produces a framing error.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = stop_bit;
        repeat (CPB) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(tag, done, 1);
    endtask

    task automatic waitErr(input string tag, input int limit);
        int n = 0;
        while (err !== 1'b1 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(tag, err, 1);
    endtask

    // Write monitor: every strobe must match the head of the scoreboard and
    // never follow another strobe directly.
    always @(negedge clk) begin
        logic [15:0] e;
        cycle++;
        if (bus.ram_write === 1'b1) begin
            writes_seen++;
            last_write_cycle = cycle;
            checkOutput("no_back_to_back", prev_write, 0);
            checkOutput("write_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("wr_addr", bus.ram_addr, e[15:8]);
                checkOutput("wr_data", bus.ram_data, e[7:0]);
            end
        end
        if (done === 1'b1 && done_prev === 1'b0) done_rise_cycle = cycle;
        prev_write = bus.ram_write;
        done_prev = done;
    end

    initial begin
        int w0;

        // Reset state
        #23;
        checkOutput("rst_ram_write", bus.ram_write, 0);
        checkOutput("rst_ram_addr", bus.ram_addr, 0);
        checkOutput("rst_ram_data", bus.ram_data, 0);
        checkOutput("rst_cpu_hold", bus.cpu_hold, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 1: three-byte load
        $display("[TB] basic 3-byte load");
        w0 = writes_seen;
        pulseStart();
        checkOutput("t1_hold_after_start", bus.cpu_hold, 1);
        exp_q.push_back({8'd0, 8'hA1});
        exp_q.push_back({8'd1, 8'hB2});
        exp_q.push_back({8'd2, 8'hC3});
        applyStimulus(8'h03, 1'b1);
        applyStimulus(8'hA1, 1'b1);
        applyStimulus(8'hB2, 1'b1);
        applyStimulus(8'hC3, 1'b1);
        waitDone("t1_done", 200);
        checkOutput("t1_hold_released", bus.cpu_hold, 0);
        checkOutput("t1_write_count", writes_seen - w0, 3);
        checkOutput("t1_done_timing", done_rise_cycle, last_write_cycle + 1);
        checkOutput("t1_addr_after", bus.ram_addr, 3);
        checkOutput("t1_queue_empty", exp_q.size(), 0);

        // 2: length 0 means 256 bytes
        $display("[TB] 256-byte load");
        w0 = writes_seen;
        pulseStart();
        checkOutput("t2_done_cleared", done, 0);
        applyStimulus(8'h00, 1'b1);
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back({i[7:0], i[7:0]});
            applyStimulus(i[7:0], 1'b1);
        end
        waitDone("t2_done", 200);
        checkOutput("t2_write_count", writes_seen - w0, 256);
        checkOutput("t2_addr_wrapped", bus.ram_addr, 0);
        checkOutput("t2_hold_released", bus.cpu_hold, 0);

        // 3: framing error mid-load
        $display("[TB] framing error");
        w0 = writes_seen;
        pulseStart();
        exp_q.push_back({8'd0, 8'h55});
        applyStimulus(8'h02, 1'b1);
        applyStimulus(8'h55, 1'b1);
        applyStimulus(8'hAA, 1'b0);
        waitErr("t3_err", 200);
        checkOutput("t3_hold_released", bus.cpu_hold, 0);
        checkOutput("t3_done_low", done, 0);
        checkOutput("t3_write_count", writes_seen - w0, 1);
        pulseStart();
        checkOutput("t3_err_cleared", err, 0);
        checkOutput("t3_hold_again", bus.cpu_hold, 1);

        // 4: short glitch in LEN is not a start bit
        $display("[TB] glitch in LEN");
        w0 = writes_seen;
        rx = 1'b0;
        repeat (2) @(posedge clk);
        #1 rx = 1'b1;
        repeat (4 * CPB) @(posedge clk);
        #1;
        checkOutput("t4_glitch_no_err", err, 0);
        exp_q.push_back({8'd0, 8'h3C});
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h3C, 1'b1);
        waitDone("t4_done", 200);
        checkOutput("t4_err_low", err, 0);
        checkOutput("t4_write_count", writes_seen - w0, 1);

        // 5: bytes without start are dropped; start during DATA is ignored
        $display("[TB] stray bytes and extra start");
        w0 = writes_seen;
        applyStimulus(8'h99, 1'b1);
        checkOutput("t5_no_write_idle", writes_seen - w0, 0);
        checkOutput("t5_done_kept", done, 1);
        pulseStart();
        exp_q.push_back({8'd0, 8'h11});
        exp_q.push_back({8'd1, 8'h22});
        applyStimulus(8'h02, 1'b1);
        applyStimulus(8'h11, 1'b1);
        pulseStart();
        checkOutput("t5_hold_mid", bus.cpu_hold, 1);
        checkOutput("t5_addr_mid", bus.ram_addr, 1);
        applyStimulus(8'h22, 1'b1);
        waitDone("t5_done", 200);
        checkOutput("t5_write_count", writes_seen - w0, 2);
        checkOutput("t5_addr_after", bus.ram_addr, 2);

        // 6: asynchronous reset mid-byte, then a fresh load
        $display("[TB] reset mid-load");
        pulseStart();
        exp_q.push_back({8'd0, 8'hE0});
        applyStimulus(8'h03, 1'b1);
        applyStimulus(8'hE0, 1'b1);
        rx = 1'b0;
        repeat (20) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_hold", bus.cpu_hold, 0);
        checkOutput("t6_rst_addr", bus.ram_addr, 0);
        checkOutput("t6_rst_data", bus.ram_data, 0);
        checkOutput("t6_rst_done_err", {done, err}, 0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        w0 = writes_seen;
        pulseStart();
        exp_q.push_back({8'd0, 8'h7E});
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h7E, 1'b1);
        waitDone("t6_done", 200);
        checkOutput("t6_write_count", writes_seen - w0, 1);
        checkOutput("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
